// File: rtl/q2_sequencer.sv
// Major-state sequencer: IDLE/FETCH/DEREF/LOAD/EXEC/ALU, two clocks per cycle,
// with run/single-step control and a 12-bit serial ALU phase.
module q2_sequencer (
    input  logic clk,
    input  logic rst_n,
    input  logic run_sw,
    input  logic step_sw,
    input  logic deref,
    input  logic o2,
    input  logic s2in,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic ns0,
    output logic ns1,
    output logic ws,
    output logic halted
);

    typedef enum logic [2:0] {IDLE, FETCH, DEREF, LOAD, EXEC, ALU} state_t;

    state_t      state, state_nx;
    logic        phase, phase_nx;
    logic [3:0]  bit_cnt, bit_cnt_nx;
    logic        step, step_nx;
    logic        boundary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            phase   <= 1'b0;
            bit_cnt <= '0;
            step    <= 1'b0;
        end else begin
            state   <= state_nx;
            phase   <= phase_nx;
            bit_cnt <= bit_cnt_nx;
            step    <= step_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        bit_cnt_nx = bit_cnt;
        step_nx    = step;
        boundary   = 1'b0;

        if (state == IDLE) begin
            phase_nx = 1'b0;
            if (step_sw || run_sw) begin
                state_nx = FETCH;
                step_nx  = step_sw;
            end
        end else if (!phase) begin
            phase_nx = 1'b1;
        end else begin
            // Decisions are taken only on the edge that ends phase 1.
            phase_nx = 1'b0;
            case (state)
                FETCH: begin
                    if (deref)   state_nx = DEREF;
                    else if (!o2) state_nx = LOAD;
                    else          state_nx = EXEC;
                end
                DEREF:   state_nx = o2 ? EXEC : LOAD;
                LOAD:    state_nx = EXEC;
                EXEC: begin
                    if (s2in) begin
                        state_nx   = ALU;
                        bit_cnt_nx = '0;
                    end else begin
                        boundary = 1'b1;
                    end
                end
                ALU: begin
                    if (bit_cnt == 4'd11) boundary   = 1'b1;
                    else                  bit_cnt_nx = bit_cnt + 4'd1;
                end
                default: state_nx = IDLE;
            endcase

            if (boundary) begin
                state_nx   = (run_sw && !step) ? FETCH : IDLE;
                step_nx    = 1'b0;
                bit_cnt_nx = '0;
            end
        end
    end

    // Outputs decode registered state only, so async reset reaches them directly.
    assign s0     = (state == DEREF) || (state == EXEC);
    assign s1     = (state == LOAD)  || (state == EXEC);
    assign s2     = (state == ALU) && (bit_cnt != 4'd11);
    assign s3     = (state == ALU) && (bit_cnt == 4'd11);
    assign ns0    = ~s0;
    assign ns1    = ~s1;
    assign ws     = (state != IDLE) && phase;
    assign halted = (state == IDLE);

endmodule
